cache_access_logger: RTL and testbench
======================================

Name: cache_access_logger

Overview:
- Receive-side counterpart of the address stream driven into mainMod.
- Each cycle mainMod may report one completed access: the address, a hit flag and the entry index ("enter").
- The block counts accesses, hits, misses and dropped records, and buffers per-access records in a FIFO.
- A downstream reader drains the FIFO with valid/ready; the block sits beside mainMod in the YACC top.

Parameters:
- ADDR_W, 32, access address width.
- ENTRY_W, 4, entry index width.
- DEPTH, 8, record FIFO depth; power of two, at least 2.
- CNT_W, 32, width of the statistics and sequence counters.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous clear of the counters and the FIFO.
- acc_valid  in  1  one access completed this cycle; no backpressure.
- acc_addr  in  ADDR_W  access address.
- acc_hit  in  1  1 = hit, 0 = miss.
- acc_entry  in  ENTRY_W  entry index used by the access.
- rec_valid  out  1  FIFO head is valid.
- rec_ready  in  1  reader accepts the head.
- rec_addr  out  ADDR_W  head record address.
- rec_hit  out  1  head record hit flag.
- rec_entry  out  ENTRY_W  head record entry index.
- rec_seq  out  CNT_W  head record sequence number, 0-based.
- total_cnt, hit_cnt, miss_cnt, drop_cnt  out  CNT_W  statistics counters.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async): all counters, level and the read/write pointers go to 0; rec_valid=0; rec_* data outputs = 0.
- Access accepted when acc_valid=1 and clear=0:
  - total_cnt +1.
  - hit_cnt +1 if acc_hit=1, otherwise miss_cnt +1.
  - All counters saturate at 2^CNT_W-1 and never wrap.
- Push:
  - The record {addr, hit, entry, seq=total_cnt value before the increment} is written if the FIFO is not full, or is full and being popped this cycle.
  - Otherwise the record is dropped and drop_cnt +1. The statistics still count the access.
- Sequence numbering: the seq field wraps modulo 2^CNT_W. It does not saturate.
- Pop: a transfer occurs on rec_valid && rec_ready. The head advances at that edge.
- Output timing: FIFO outputs are first-word-fall-through.
  - rec_valid = (level != 0); rec_* always reflect the head entry.
  - Latency: a push at edge N into an empty FIFO gives rec_valid=1 in the cycle after edge N.
- Empty FIFO with rec_ready=1: no pop, no state change.
- Simultaneous push and pop: level is unchanged. When full, the push is accepted.
- Pointers wrap modulo DEPTH; level ranges 0..DEPTH.
- clear=1: on the next edge, counters, pointers and level go to 0.
  - Any acc_valid in the same cycle is ignored.
  - Any rec_ready in the same cycle is ignored.
- Reset mid-stream: contents are discarded. No record is emitted after reset until a new access arrives.
- rec_* data must stay stable while rec_valid=1 and rec_ready=0.

Optional Feature:
- Macro: LOGGER_TIMESTAMP_EN.
- Defined:
  - Adds a free-running CNT_W cycle counter, cleared by reset and by clear, incrementing every cycle and wrapping.
  - Each record stores the counter value at push time.
  - New output port rec_time (CNT_W) presents it for the head record.
- Undefined: no counter and no rec_time port; all other behaviour is identical.

Decomposition:
- Package yacc_log_pkg holds:
  - ADDR_W/ENTRY_W/CNT_W defaults.
  - The typedef acc_rec_t packing {addr, hit, entry, seq[, time]}.
  - The saturating-increment function.
- One sub-module, log_rec_fifo:
  - Parameterised by DEPTH and record width.
  - Contains the pointers, level, full/empty and the FWFT head.
- cache_access_logger holds the counters, the drop logic and the clear handling.

Test Plan:
- Reset with acc_valid=1 held -> all outputs 0, rec_valid=0; after deassert, first access addr 0x0040_1000 hit -> rec_valid next cycle, rec_seq=0, hit_cnt=1.
- 10 back-to-back accesses, rec_ready=0, DEPTH=8 -> level=8, drop_cnt=2, total_cnt=10; drain yields seq 0..7 in order.
- FIFO full, acc_valid=1 and rec_ready=1 in the same cycle -> drop_cnt unchanged, level stays 8, head seq increments by 1.
- Accesses alternating hit/miss with rec_ready toggling randomly, 1000 cycles -> hit_cnt+miss_cnt=total_cnt; records drained match the reference queue exactly; rec_* stable while stalled.
- CNT_W=4, 20 accesses with rec_ready=1 -> total_cnt saturates at 15; rec_seq wraps to 0 after 15.
- clear asserted with acc_valid=1 and 3 records queued -> next cycle level=0, all counters 0, access not counted; with LOGGER_TIMESTAMP_EN, rec_time of the next push equals the cycles elapsed since clear.

Source files
------------

// File: rtl/yacc_log_pkg.sv
// Shared widths, record layout and saturating-increment helper for the cache access logger.
// LOGGER_TIMESTAMP_EN adds a cycle-stamp field to the record.
package yacc_log_pkg;

    localparam int unsigned ADDR_W_DEF  = 32;
    localparam int unsigned ENTRY_W_DEF = 4;
    localparam int unsigned CNT_W_DEF   = 32;
    localparam int unsigned SAT_MAX_W   = 64;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0]  addr;
        logic                   hit;
        logic [ENTRY_W_DEF-1:0] entry;
        logic [CNT_W_DEF-1:0]   seq;
`ifdef LOGGER_TIMESTAMP_EN
        logic [CNT_W_DEF-1:0]   stamp;
`endif
    } acc_rec_t;

    // Increment v, holding at the all-ones value of a w-bit counter.
    function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] v,
                                                     input int unsigned w);
        logic [SAT_MAX_W-1:0] max_v;
        max_v = {SAT_MAX_W{1'b1}} >> (SAT_MAX_W - w);
        return (v >= max_v) ? v : v + SAT_MAX_W'(1);
    endfunction

endpackage

// File: rtl/log_rec_fifo.sv
// First-word-fall-through record FIFO; a push into a full FIFO is taken when a pop happens the same cycle.
module log_rec_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   push,
    input  logic [W-1:0]           wdata,
    input  logic                   pop,
    output logic [W-1:0]           rdata_c,
    output logic                   valid_c,
    output logic                   push_ok_c,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [W-1:0]     mem_q [DEPTH];
    logic             do_pop;
    logic             full;

    always_comb begin
        full      = (level_q == LVL_W'(DEPTH));
        valid_c   = (level_q != '0);
        do_pop    = pop && valid_c;
        push_ok_c = push && (!full || do_pop);
        rdata_c   = valid_c ? mem_q[rd_ptr_q] : '0;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)    rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push_ok_c && !do_pop)      level_d = level_q + LVL_W'(1);
            else if (do_pop && !push_ok_c) level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is not reset; empty-state output is masked to zero instead.
    always_ff @(posedge clock) begin
        if (push_ok_c && !clear) mem_q[wr_ptr_q] <= wdata;
    end

    assign level = level_q;

endmodule

// File: rtl/cache_access_logger.sv
// Counts completed cache accesses and buffers per-access records for a valid/ready reader.
// LOGGER_TIMESTAMP_EN adds a free-running cycle counter stamped into each record (rec_time).
module cache_access_logger
    import yacc_log_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned ENTRY_W = ENTRY_W_DEF,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   acc_valid,
    input  logic [ADDR_W-1:0]      acc_addr,
    input  logic                   acc_hit,
    input  logic [ENTRY_W-1:0]     acc_entry,
    output logic                   rec_valid,
    input  logic                   rec_ready,
    output logic [ADDR_W-1:0]      rec_addr,
    output logic                   rec_hit,
    output logic [ENTRY_W-1:0]     rec_entry,
    output logic [CNT_W-1:0]       rec_seq,
    output logic [CNT_W-1:0]       total_cnt,
    output logic [CNT_W-1:0]       hit_cnt,
    output logic [CNT_W-1:0]       miss_cnt,
    output logic [CNT_W-1:0]       drop_cnt,
`ifdef LOGGER_TIMESTAMP_EN
    output logic [CNT_W-1:0]       rec_time,
`endif
    output logic [$clog2(DEPTH):0] level
);

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic               hit;
        logic [ENTRY_W-1:0] entry;
        logic [CNT_W-1:0]   seq;
`ifdef LOGGER_TIMESTAMP_EN
        logic [CNT_W-1:0]   stamp;
`endif
    } rec_t;

    localparam int unsigned REC_W = $bits(rec_t);

    logic [CNT_W-1:0] total_q, total_d;
    logic [CNT_W-1:0] hit_q, hit_d;
    logic [CNT_W-1:0] miss_q, miss_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] seq_q, seq_d;
`ifdef LOGGER_TIMESTAMP_EN
    logic [CNT_W-1:0] time_q, time_d;
`endif

    logic             acc_c;
    logic             pop_c;
    logic             push_ok_c;
    logic             head_valid_c;
    logic [REC_W-1:0] head_bits_c;
    rec_t             wr_rec;
    rec_t             head_rec;

    // clear masks both sides of the FIFO for the cycle it is asserted.
    always_comb begin
        acc_c          = acc_valid && !clear;
        pop_c          = rec_ready && !clear;
        wr_rec         = '0;
        wr_rec.addr    = acc_addr;
        wr_rec.hit     = acc_hit;
        wr_rec.entry   = acc_entry;
        wr_rec.seq     = seq_q;
`ifdef LOGGER_TIMESTAMP_EN
        wr_rec.stamp   = time_q;
`endif
    end

    log_rec_fifo #(
        .DEPTH (DEPTH),
        .W     (REC_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear),
        .push      (acc_c),
        .wdata     (wr_rec),
        .pop       (pop_c),
        .rdata_c   (head_bits_c),
        .valid_c   (head_valid_c),
        .push_ok_c (push_ok_c),
        .level     (level)
    );

    always_comb begin
        total_d = total_q;
        hit_d   = hit_q;
        miss_d  = miss_q;
        drop_d  = drop_q;
        seq_d   = seq_q;
        if (clear) begin
            total_d = '0;
            hit_d   = '0;
            miss_d  = '0;
            drop_d  = '0;
            seq_d   = '0;
        end else if (acc_c) begin
            total_d = CNT_W'(sat_inc(SAT_MAX_W'(total_q), CNT_W));
            seq_d   = seq_q + CNT_W'(1);
            if (acc_hit) hit_d  = CNT_W'(sat_inc(SAT_MAX_W'(hit_q), CNT_W));
            else         miss_d = CNT_W'(sat_inc(SAT_MAX_W'(miss_q), CNT_W));
            if (!push_ok_c) drop_d = CNT_W'(sat_inc(SAT_MAX_W'(drop_q), CNT_W));
        end
    end

`ifdef LOGGER_TIMESTAMP_EN
    always_comb begin
        time_d = clear ? '0 : time_q + CNT_W'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) time_q <= '0;
        else       time_q <= time_d;
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            total_q <= '0;
            hit_q   <= '0;
            miss_q  <= '0;
            drop_q  <= '0;
            seq_q   <= '0;
        end else begin
            total_q <= total_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            drop_q  <= drop_d;
            seq_q   <= seq_d;
        end
    end

    always_comb begin
        head_rec  = head_bits_c;
        rec_valid = head_valid_c;
        rec_addr  = head_rec.addr;
        rec_hit   = head_rec.hit;
        rec_entry = head_rec.entry;
        rec_seq   = head_rec.seq;
`ifdef LOGGER_TIMESTAMP_EN
        rec_time  = head_rec.stamp;
`endif
    end

    assign total_cnt = total_q;
    assign hit_cnt   = hit_q;
    assign miss_cnt  = miss_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_cache_access_logger.sv
// Scoreboard bench for cache_access_logger: default instance plus a CNT_W=4 instance for saturation.
module tb_cache_access_logger;
    import yacc_log_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        acc_valid = 1'b0;
    logic [31:0] acc_addr = '0;
    logic        acc_hit = 1'b0;
    logic [3:0]  acc_entry = '0;
    logic        rec_ready = 1'b0;

    logic        rec_valid, rec_hit;
    logic [31:0] rec_addr, rec_seq, total_cnt, hit_cnt, miss_cnt, drop_cnt;
    logic [3:0]  rec_entry, level;

    logic        rec_valid4, rec_hit4;
    logic [31:0] rec_addr4;
    logic [3:0]  rec_entry4, level4;
    logic [3:0]  rec_seq4, total4, hit4, miss4, drop4;
`ifdef LOGGER_TIMESTAMP_EN
    logic [31:0] rec_time;
    logic [3:0]  rec_time4;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    acc_rec_t    exp_q[$];
    logic [31:0] m_total, m_hit, m_miss, m_drop, m_seq;

    cache_access_logger dut (
        .clock(clock), .reset(reset), .clear(clear),
        .acc_valid(acc_valid), .acc_addr(acc_addr), .acc_hit(acc_hit), .acc_entry(acc_entry),
        .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_addr(rec_addr), .rec_hit(rec_hit), .rec_entry(rec_entry), .rec_seq(rec_seq),
        .total_cnt(total_cnt), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .drop_cnt(drop_cnt),
`ifdef LOGGER_TIMESTAMP_EN
        .rec_time(rec_time),
`endif
        .level(level)
    );

    cache_access_logger #(.CNT_W(4)) dut4 (
        .clock(clock), .reset(reset), .clear(clear),
        .acc_valid(acc_valid), .acc_addr(acc_addr), .acc_hit(acc_hit), .acc_entry(acc_entry),
        .rec_valid(rec_valid4), .rec_ready(rec_ready),
        .rec_addr(rec_addr4), .rec_hit(rec_hit4), .rec_entry(rec_entry4), .rec_seq(rec_seq4),
        .total_cnt(total4), .hit_cnt(hit4), .miss_cnt(miss4), .drop_cnt(drop4),
`ifdef LOGGER_TIMESTAMP_EN
        .rec_time(rec_time4),
`endif
        .level(level4)
    );

    always #5 clock = ~clock;

    // Head of the DUT FIFO must always match the reference queue front; pop on transfer.
    always @(negedge clock) begin
        if (!reset) begin
            vec_cnt++;
            if (rec_valid !== (exp_q.size() != 0)) begin
                err_cnt++;
                $display("FAIL mon_valid: rec_valid=%b, expected %b", rec_valid, exp_q.size() != 0);
            end else if (rec_valid) begin
                vec_cnt++;
                if (rec_addr !== exp_q[0].addr || rec_hit !== exp_q[0].hit ||
                    rec_entry !== exp_q[0].entry || rec_seq !== exp_q[0].seq) begin
                    err_cnt++;
                    $display("FAIL mon_head: got addr=%h hit=%b entry=%h seq=%0d, expected addr=%h hit=%b entry=%h seq=%0d",
                             rec_addr, rec_hit, rec_entry, rec_seq,
                             exp_q[0].addr, exp_q[0].hit, exp_q[0].entry, exp_q[0].seq);
                end
                if (rec_ready && !clear) void'(exp_q.pop_front());
            end
        end
    end

    task automatic model_clear();
        exp_q.delete();
        m_total = '0; m_hit = '0; m_miss = '0; m_drop = '0; m_seq = '0;
    endtask

    // Drive one cycle at posedge+1; model is updated at the edge; returns at the next posedge+1.
    task automatic drive(input logic v, input logic [31:0] a, input logic h,
                         input logic [3:0] e, input logic r, input logic c);
        acc_rec_t rec;
        logic     do_push;
        acc_valid = v; acc_addr = a; acc_hit = h; acc_entry = e; rec_ready = r; clear = c;
        rec       = '0;
        do_push   = 1'b0;
        if (!c && v) begin
            rec.addr = a; rec.hit = h; rec.entry = e; rec.seq = m_seq;
            do_push  = (exp_q.size() < 8) || (r && exp_q.size() != 0);
        end
        @(posedge clock);
        if (c) begin
            model_clear();
        end else if (v) begin
            if (m_total != 32'hFFFF_FFFF) m_total++;
            if (h) m_hit++; else m_miss++;
            m_seq++;
            if (do_push) exp_q.push_back(rec);
            else         m_drop++;
        end
        #1;
    endtask

    task automatic do_reset();
        acc_valid = 1'b0; rec_ready = 1'b0; clear = 1'b0;
        reset = 1'b1;
        model_clear();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        model_clear();
        reset = 1'b1; acc_valid = 1'b1; acc_hit = 1'b1; acc_addr = 32'hDEAD_BEEF; rec_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        vec_cnt++;
        if ({rec_valid, level, total_cnt, hit_cnt, miss_cnt, drop_cnt} !== '0) begin
            err_cnt++;
            $display("FAIL reset_state: valid=%b level=%0d total=%0d hit=%0d miss=%0d drop=%0d, expected all 0",
                     rec_valid, level, total_cnt, hit_cnt, miss_cnt, drop_cnt);
        end
        vec_cnt++;
        if ({rec_addr, rec_hit, rec_entry, rec_seq} !== '0) begin
            err_cnt++;
            $display("FAIL reset_data: addr=%h hit=%b entry=%h seq=%0d, expected 0", rec_addr, rec_hit, rec_entry, rec_seq);
        end
        acc_valid = 1'b0; rec_ready = 1'b0;
        reset = 1'b0;
        drive(1'b1, 32'h0040_1000, 1'b1, 4'h3, 1'b0, 1'b0);
        vec_cnt++;
        if (rec_valid !== 1'b1 || rec_seq !== 32'd0 || rec_addr !== 32'h0040_1000 || hit_cnt !== 32'd1) begin
            err_cnt++;
            $display("FAIL first_access: valid=%b seq=%0d addr=%h hit_cnt=%0d, expected 1 0 00401000 1",
                     rec_valid, rec_seq, rec_addr, hit_cnt);
        end
        vec_cnt++;
        if (total_cnt !== 32'd1 || miss_cnt !== 32'd0 || level !== 4'd1) begin
            err_cnt++;
            $display("FAIL first_counts: total=%0d miss=%0d level=%0d, expected 1 0 1", total_cnt, miss_cnt, level);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 10; i++)
            drive(1'b1, 32'h1000 + 32'(i * 4), (i % 2) == 0, 4'(i), 1'b0, 1'b0);
        vec_cnt++;
        if (level !== 4'd8 || drop_cnt !== 32'd2 || total_cnt !== 32'd10) begin
            err_cnt++;
            $display("FAIL overflow: level=%0d drop=%0d total=%0d, expected 8 2 10", level, drop_cnt, total_cnt);
        end
        for (int i = 0; i < 8; i++) begin
            vec_cnt++;
            if (rec_seq !== 32'(i)) begin
                err_cnt++;
                $display("FAIL drain_order: seq=%0d, expected %0d", rec_seq, i);
            end
            drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        end
        vec_cnt++;
        if (level !== 4'd0 || rec_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL drain_empty: level=%0d valid=%b, expected 0 0", level, rec_valid);
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < 8; i++)
            drive(1'b1, 32'h2000 + 32'(i), 1'b0, 4'(i), 1'b0, 1'b0);
        vec_cnt++;
        if (level !== 4'd8 || rec_seq !== 32'd0) begin
            err_cnt++;
            $display("FAIL full_fill: level=%0d seq=%0d, expected 8 0", level, rec_seq);
        end
        drive(1'b1, 32'h2ABC, 1'b1, 4'hF, 1'b1, 1'b0);
        vec_cnt++;
        if (drop_cnt !== 32'd0 || level !== 4'd8 || rec_seq !== 32'd1 || total_cnt !== 32'd9) begin
            err_cnt++;
            $display("FAIL full_push_pop: drop=%0d level=%0d seq=%0d total=%0d, expected 0 8 1 9",
                     drop_cnt, level, rec_seq, total_cnt);
        end
        for (int i = 0; i < 8; i++) drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_empty_pop();
        repeat (2) drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        vec_cnt++;
        if (level !== 4'd0 || rec_valid !== 1'b0 || total_cnt !== 32'd9 || drop_cnt !== 32'd0) begin
            err_cnt++;
            $display("FAIL empty_pop: level=%0d valid=%b total=%0d drop=%0d, expected 0 0 9 0",
                     level, rec_valid, total_cnt, drop_cnt);
        end
    endtask

    task automatic test_random();
        logic hit_t;
        do_reset();
        hit_t = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            logic v;
            v = ($urandom_range(0, 3) != 0);
            drive(v, $urandom, hit_t, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
            if (v) hit_t = ~hit_t;
        end
        vec_cnt++;
        if (total_cnt !== m_total || hit_cnt !== m_hit || miss_cnt !== m_miss || drop_cnt !== m_drop) begin
            err_cnt++;
            $display("FAIL random_counts: total=%0d hit=%0d miss=%0d drop=%0d, expected %0d %0d %0d %0d",
                     total_cnt, hit_cnt, miss_cnt, drop_cnt, m_total, m_hit, m_miss, m_drop);
        end
        vec_cnt++;
        if (32'(hit_cnt + miss_cnt) !== total_cnt || level !== 4'(exp_q.size())) begin
            err_cnt++;
            $display("FAIL random_sum: hit+miss=%0d total=%0d level=%0d, expected level %0d",
                     32'(hit_cnt + miss_cnt), total_cnt, level, exp_q.size());
        end
        for (int i = 0; i < 12 && rec_valid; i++) drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        vec_cnt++;
        if (level !== 4'd0) begin
            err_cnt++;
            $display("FAIL random_drain: level=%0d, expected 0", level);
        end
    endtask

    task automatic test_clear();
        do_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h3000 + 32'(i), 1'b1, 4'(i), 1'b0, 1'b0);
        vec_cnt++;
        if (level !== 4'd3) begin
            err_cnt++;
            $display("FAIL clear_fill: level=%0d, expected 3", level);
        end
        drive(1'b1, 32'h3FFF, 1'b1, 4'h7, 1'b1, 1'b1);
        vec_cnt++;
        if ({level, rec_valid, total_cnt, hit_cnt, miss_cnt, drop_cnt} !== '0) begin
            err_cnt++;
            $display("FAIL clear: level=%0d valid=%b total=%0d hit=%0d miss=%0d drop=%0d, expected all 0",
                     level, rec_valid, total_cnt, hit_cnt, miss_cnt, drop_cnt);
        end
        repeat (2) drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        drive(1'b1, 32'h3100, 1'b0, 4'h1, 1'b0, 1'b0);
        vec_cnt++;
        if (rec_seq !== 32'd0 || total_cnt !== 32'd1 || miss_cnt !== 32'd1) begin
            err_cnt++;
            $display("FAIL clear_restart: seq=%0d total=%0d miss=%0d, expected 0 1 1", rec_seq, total_cnt, miss_cnt);
        end
`ifdef LOGGER_TIMESTAMP_EN
        vec_cnt++;
        if (rec_time !== 32'd2) begin
            err_cnt++;
            $display("FAIL clear_time: rec_time=%0d, expected 2", rec_time);
        end
`endif
        drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 32'h4000 + 32'(k), 1'b1, 4'h2, 1'b1, 1'b0);
            vec_cnt++;
            if (total4 !== 4'((k + 1 > 15) ? 15 : k + 1) || hit4 !== total4 ||
                rec_seq4 !== 4'(k % 16) || rec_valid4 !== 1'b1) begin
                err_cnt++;
                $display("FAIL saturation k=%0d: total=%0d hit=%0d seq=%0d valid=%b, expected %0d %0d %0d 1",
                         k, total4, hit4, rec_seq4, rec_valid4,
                         (k + 1 > 15) ? 15 : k + 1, (k + 1 > 15) ? 15 : k + 1, k % 16);
            end
        end
        drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_overflow();
        test_full_push_pop();
        test_empty_pop();
        test_random();
        test_clear();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
